// File: rtl/remote_cmd_tx.sv
// remote_cmd_tx: sends one 3-byte command frame (opcode, payload hi, payload lo)
// through a UART transmitter, then waits for a single response byte.
//
// Optional feature: define RESP_TIMEOUT_EN to bound the response wait.
//   FAST_SIM=1 -> timeout after 512 WAIT_RESP cycles, otherwise 2^25 cycles.
//   Without the macro the wait is unbounded and timeout is tied low.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   snd_cmd, cmd, data  request to send; cmd/data captured on acceptance
//   tx_data, trmt       byte to UART TX and its one-cycle start pulse
//   tx_done             UART TX finished the current byte
//   rx_rdy, rx_data     UART RX holds a valid byte
//   clr_rx_rdy          one-cycle pulse clearing rx_rdy in the UART
//   resp, resp_rdy      last response byte and its valid flag
//   ack_ok              resp_rdy with resp == 8'hA5
//   busy                any state other than IDLE
//   timeout             one-cycle pulse when the response wait expires
module remote_cmd_tx #(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        ack_ok,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, TX_CMD, TX_HI, TX_LO, WAIT_RESP} state_t;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;

`ifdef RESP_TIMEOUT_EN
  localparam int CNT_W = 25;
  // Last counter value before expiry: the counter starts at 0 on entry, so
  // expiry lands exactly LIMIT cycles after WAIT_RESP entry.
  localparam logic [CNT_W-1:0] TO_LAST = (FAST_SIM != 0) ? CNT_W'(511) : {CNT_W{1'b1}};
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Byte select straight from the shadow registers: stable for the whole state.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      TX_CMD:  tx_data = cmd_q;
      TX_HI:   tx_data = data_q[15:8];
      TX_LO:   tx_data = data_q[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  assign busy   = (state != IDLE);
  assign ack_ok = resp_rdy && (resp == 8'hA5);

  // trmt is high only in the first cycle of a TX state, so gating tx_done with
  // !trmt ignores a done that coincides with the start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= 8'h00;
      data_q     <= 16'h0000;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp       <= 8'h00;
      resp_rdy   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      to_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: if (snd_cmd) begin
          cmd_q      <= cmd;
          data_q     <= data;
          resp_rdy   <= 1'b0;
          clr_rx_rdy <= 1'b1;   // flush any stale receive byte
          trmt       <= 1'b1;
          state      <= TX_CMD;
        end
        TX_CMD: if (!trmt && tx_done) begin
          trmt  <= 1'b1;
          state <= TX_HI;
        end
        TX_HI: if (!trmt && tx_done) begin
          trmt  <= 1'b1;
          state <= TX_LO;
        end
        TX_LO: if (!trmt && tx_done) begin
`ifdef RESP_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state  <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // rx_rdy has priority over expiry in the same cycle.
          if (rx_rdy) begin
            resp       <= rx_data;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            state      <= IDLE;
          end
`ifdef RESP_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
